mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and scheduler sharing one pipelined signed multiplier among NREQ requesters. Each requester offers a signed operand pair with a valid/ready handshake. The block grants at most one requester per cycle, issues the pair into a LAT-stage multiplier pipeline, and broadcasts the full-precision product tagged with the requester ID. It sits between the requester datapaths and the shared multiplier resource, with a global enable that freezes the whole schedule.

## Interface
Parameters:
- NREQ, 4: number of requesters, ≥2.
- W, 8: operand width, signed two's complement.
- LAT, 2: multiplier pipeline depth in cycles, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; low freezes pointer, pipeline, outputs; no grants.
- req_valid  in  NREQ  per-requester operand pair valid.
- req_a  in  NREQ×W  signed operand A per requester.
- req_b  in  NREQ×W  signed operand B per requester.
- req_ready  out  NREQ  one-hot-or-zero grant; a transfer occurs when valid & ready.
- res_valid  out  1  product valid this cycle; single-cycle pulse per issued pair, no backpressure.
- res_id  out  $clog2(NREQ)  requester index of the product.
- res_p  out  2W  signed product a*b.

## Operation
- Round-robin pointer ptr, range 0..NREQ-1, reset 0.
- The arbiter searches from ptr upward with wrap: ptr, ptr+1, …, NREQ-1, 0, …. The first index i with req_valid[i] gets the grant.
- req_ready[i] = en & !rst & (i is the winner). It is combinational from req_valid, and requesters must not make valid depend on ready.
- On a grant to i: ptr <= (i+1) mod NREQ. With no valid requester, ptr holds.
- The granted pair {req_a[i], req_b[i], i} enters pipeline stage 1 with valid=1. A non-grant cycle inserts a bubble (valid=0).
- Arithmetic: signed W×W to 2W, full precision, no truncation or saturation. Operands are sign-extended before the multiply.
- When en=1, the pipeline advances every cycle. When en=0, every stage register and ptr holds.
- res_valid = last-stage valid & en. A held result is therefore not re-reported while frozen, and it reports once when en returns.
- res_p and res_id are driven from the last stage. When res_valid=0 they hold their last value.
- Reset state: ptr=0, all stage valids 0, res_p=0, res_id=0. res_valid=0 and req_ready=0 during reset.

## Timing
- A grant in cycle t produces res_valid in cycle t+LAT, provided en stays high. Each cycle of en=0 in between adds one cycle.
- Throughput is one product per cycle sustained.
- With all requesters continuously valid, grants go 0,1,2,3,0,… with no starvation. The worst-case wait is NREQ-1 grant cycles.
- If requester i drops valid and a later index is valid, that index is granted in the same cycle with no idle cycle.
- A requester granted in cycle t is not eligible first in cycle t+1; it is served last in the rotation.
- Reset asserted mid-operation flushes all in-flight products: they are discarded and no res_valid is produced for them. ptr returns to 0 on the next edge.
- Boundary checks:
  - ptr at NREQ-1 with a grant wraps to 0.
  - A single active requester is granted every cycle.
  - en=0 with requests pending produces no grants and all req_ready=0.

## Structure
- Package mult_share_pkg:
  - default W, NREQ, LAT localparams.
  - typedef id_t (logic [$clog2(NREQ)-1:0]).
  - typedef prod_t (logic signed [2W-1:0]).
  - struct stage_t {valid, id, a, b / p}.
- Sub-module mult_pipe: LAT-stage signed multiplier with en-gated advance, carrying valid and id alongside the data. It has a synchronous rst that clears only the valid bits.
- Top level holds the round-robin pointer, the priority search and the grant decode.

## Test plan
- Reset, then a single request: requester 2 sends a=3, b=-5 → req_ready=4'b0100 in the same cycle; at t+2, res_valid=1, res_id=2, res_p=-15 (0xFFF1).
- Extremes: a=-128, b=-128 → res_p=16384 (0x4000). a=127, b=-128 → res_p=-16256 (0xC080).
- All four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; res_id follows the same order two cycles later, one per cycle.
- Requesters 1 and 3 valid with ptr=2 → requester 3 is granted first, then requester 1 (wrap), then 3 again.
- Issue in cycle t, then en=0 for 3 cycles starting at t+1 → no grants, res_valid stays 0 and ptr holds while frozen; the product appears at t+5.
- Two products in flight, then rst for 1 cycle → no res_valid ever for those products; ptr=0 and outputs are zero after reset.

Source files
------------

// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared defaults, types and index helper for the multiplier-sharing arbiter.
package mult_share_pkg;
    localparam int NREQ_D = 4;
    localparam int W_D    = 8;
    localparam int LAT_D  = 2;

    typedef logic [$clog2(NREQ_D)-1:0] id_t;
    typedef logic signed [2*W_D-1:0]   prod_t;

    typedef struct packed {
        logic                   valid;
        id_t                    id;
        logic signed [W_D-1:0]  a;
        logic signed [W_D-1:0]  b;
        prod_t                  p;
    } stage_t;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off >= n) ? base + off - n : base + off;
    endfunction
endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: LAT-stage signed multiplier; valid and id travel with the product, all stages freeze when en_i is low.
module mult_pipe
    import mult_share_pkg::*;
#(
    parameter int W   = W_D,
    parameter int IDW = $clog2(NREQ_D),
    parameter int LAT = LAT_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  in_valid_i,
    input  logic [IDW-1:0]        in_id_i,
    input  logic signed [W-1:0]   in_a_i,
    input  logic signed [W-1:0]   in_b_i,
    output logic                  out_valid_o,
    output logic [IDW-1:0]        out_id_o,
    output logic signed [2*W-1:0] out_p_o
);
    logic [LAT-1:0]         v_q;
    logic [IDW-1:0]         id_q [LAT];
    logic signed [2*W-1:0]  p_q  [LAT];
    logic signed [2*W-1:0]  ax, bx, prod;

    assign ax   = {{W{in_a_i[W-1]}}, in_a_i};
    assign bx   = {{W{in_b_i[W-1]}}, in_b_i};
    assign prod = ax * bx;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else if (en_i) begin
            v_q[0] <= in_valid_i;
            for (int k = 1; k < LAT; k++) v_q[k] <= v_q[k-1];
        end
    end

    // Data only moves with a valid token so the last stage keeps the most recent product across bubbles.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (in_valid_i) begin
                id_q[0] <= in_id_i;
                p_q[0]  <= prod;
            end
            for (int k = 1; k < LAT; k++) begin
                if (v_q[k-1]) begin
                    id_q[k] <= id_q[k-1];
                    p_q[k]  <= p_q[k-1];
                end
            end
        end
    end

    assign out_valid_o = v_q[LAT-1];
    assign out_id_o    = id_q[LAT-1];
    assign out_p_o     = p_q[LAT-1];
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin grant of one shared pipelined signed multiplier among NREQ requesters.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_D,
    parameter int W    = W_D,
    parameter int LAT  = LAT_D
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*W-1:0]         req_a_i,
    input  logic [NREQ*W-1:0]         req_b_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic                      res_valid_o,
    output logic [$clog2(NREQ)-1:0]   res_id_o,
    output logic signed [2*W-1:0]     res_p_o
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]         ptr_q, ptr_d, win, idx;
    logic                   found, grant;
    logic                   pv;
    logic [IDW-1:0]         pid, last_id_q;
    logic signed [2*W-1:0]  pp, last_p_q;

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'(wrap_add(int'(ptr_q), k, NREQ));
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant       = en_i & ~rst & found;
        req_ready_o = grant ? NREQ'(1) << win : '0;
        ptr_d       = grant ? (win == IDW'(NREQ-1) ? '0 : win + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;

    mult_pipe #(.W(W), .IDW(IDW), .LAT(LAT)) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .in_valid_i  (grant),
        .in_id_i     (win),
        .in_a_i      (req_a_i[win*W +: W]),
        .in_b_i      (req_b_i[win*W +: W]),
        .out_valid_o (pv),
        .out_id_o    (pid),
        .out_p_o     (pp)
    );

    assign res_valid_o = pv & en_i & ~rst;

    // Reported values hold between pulses and read zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_p_q  <= '0;
            last_id_q <= '0;
        end else if (res_valid_o) begin
            last_p_q  <= pp;
            last_id_q <= pid;
        end
    end

    assign res_p_o  = res_valid_o ? pp  : last_p_q;
    assign res_id_o = res_valid_o ? pid : last_id_q;
endmodule
